// File: rtl/glonass_pkg.sv
// Shared constants for the GLONASS signal path.
// The chip-rate ratio is reduced by gcd so that the fractional divider
// uses the smallest accumulator that still gives an exact output rate.
package glonass_pkg;

  localparam int unsigned SYS_CLK_HZ  = 5_000_000;
  localparam int unsigned GLO_CHIP_HZ = 511_000;

  // Greatest common divisor, evaluated at elaboration time.
  function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
    int unsigned x;
    int unsigned y;
    int unsigned t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Reduced ratio SYS_CLK_HZ / GLO_CHIP_HZ = 5000 / 511.
  localparam int unsigned GLO_MOD = SYS_CLK_HZ / gcd(SYS_CLK_HZ, GLO_CHIP_HZ);
  localparam int unsigned GLO_INC = GLO_CHIP_HZ / gcd(SYS_CLK_HZ, GLO_CHIP_HZ);

  // Registered output pair of the generator.
  typedef struct packed {
    logic clk;
    logic tick;
  } gen_out_t;

endpackage

// File: rtl/frac_phase_acc.sv
// Modulo phase accumulator: acc advances by INC every clk and wraps at MOD.
// acc_d is the value acc_q will take at the next edge; wrap flags that this
// edge subtracts MOD.
module frac_phase_acc
  import glonass_pkg::*;
#(
  parameter int unsigned MOD = GLO_MOD,
  parameter int unsigned INC = GLO_INC,
  localparam int unsigned ACC_W = $clog2(MOD + INC)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [ACC_W-1:0] acc_q,
  output logic [ACC_W-1:0] acc_d,
  output logic             wrap
);

  localparam logic [ACC_W-1:0] MOD_W = ACC_W'(MOD);
  localparam logic [ACC_W-1:0] INC_W = ACC_W'(INC);

  // Reject increments that would leave one phase of the output empty.
  if (INC == 0 || INC > MOD / 2) begin : g_bad_inc
    $error("frac_phase_acc: INC must satisfy 0 < INC <= MOD/2");
  end

  logic [ACC_W-1:0] sum;

  // Next accumulator value; ACC_W covers MOD+INC so the sum never overflows.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    sum   = acc_q + INC_W;
    wrap  = (sum >= MOD_W);
    acc_d = wrap ? (sum - MOD_W) : sum;
  end

  // Accumulator register, cleared asynchronously so phase restarts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/gen_511k_frac.sv
// Fractional-N 511 kHz generator from the 5 MHz system clock.
// The output is high while the accumulator sits in the upper half of its
// range, giving INC rising edges per MOD clocks with one-cycle jitter.
module gen_511k_frac
  import glonass_pkg::*;
#(
  parameter int unsigned MOD = GLO_MOD,
  parameter int unsigned INC = GLO_INC
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_511k,
  output logic tick_511k
);

  localparam int unsigned      ACC_W  = $clog2(MOD + INC);
  localparam logic [ACC_W-1:0] HALF_W = ACC_W'(MOD / 2);
  localparam logic [ACC_W-1:0] INC_W  = ACC_W'(INC);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             wrap;
  gen_out_t         out_q;
  gen_out_t         out_d;

  frac_phase_acc #(
    .MOD (MOD),
    .INC (INC)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .acc_q (acc_q),
    .acc_d (acc_d),
    .wrap  (wrap)
  );

  // Output level follows the next accumulator value so clk_511k and acc stay aligned.
  always_comb begin
    out_d      = '0;
    out_d.clk  = (acc_d >= HALF_W);
    out_d.tick = out_d.clk & ~out_q.clk;
  end

  // Output registers; reset drops both outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: asynchronous reset lets outputs fall without waiting for a clk edge.
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign clk_511k  = out_q.clk;
  assign tick_511k = out_q.tick;

  // After a wrap the remainder is always below INC, since acc_q < MOD.
  a_wrap_remainder : assert property (
    @(posedge clk) disable iff (!rst_n) wrap |-> (acc_d < INC_W)
  );

endmodule

// File: tb/tb_gen_511k_frac.sv
// Testbench for gen_511k_frac: scoreboard against a modulo-arithmetic model,
// plus directed measurements of latency, edge count, period and duty.
module tb_gen_511k_frac;

  localparam int T_MOD  = 5000;
  localparam int T_INC  = 511;
  localparam int T_HALF = 2500;

  typedef struct packed {
    logic c;
    logic t;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clk_511k;
  logic tick_511k;
  logic c2;
  logic t2;
  bit   done = 1'b0;

  int passed = 0;
  int total  = 0;

  exp_t sb_q[$];

  gen_511k_frac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_511k  (clk_511k),
    .tick_511k (tick_511k)
  );

  gen_511k_frac #(.MOD(10), .INC(5)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_511k  (c2),
    .tick_511k (t2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase = (n * INC) mod MOD after n edges; output high in upper half.
  int  m_phase  = 0;
  bit  m_prev_c = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_phase  = 0;
      m_prev_c = 1'b0;
      e        = '0;
    end else begin
      m_phase  = (m_phase + T_INC) % T_MOD;
      e.c      = (m_phase >= T_HALF);
      e.t      = e.c && !m_prev_c;
      m_prev_c = e.c;
    end
    sb_q.push_back(e);
  end

  // Monitor: pop one expectation per cycle and compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!done) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        if (!rst_n) e = '0;
        check("sb_clk_511k", int'(clk_511k), int'(e.c));
        check("sb_tick_511k", int'(tick_511k), int'(e.t));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_rise;
    int rises;
    int ticks;
    int dbl_ticks;
    int last_rise;
    int per_min;
    int per_max;
    int hi_run;
    int hi_min;
    int hi_max;
    int rises2;
    bit prev_c;
    bit prev_t;
    bit prev_c2;
    bit c;
    bit t;

    // Reset held with clk running.
    repeat (6) @(negedge clk);
    check("reset_acc", int'(dut.u_acc.acc_q), 0);
    check("reset_clk", int'(clk_511k), 0);
    check("reset_tick", int'(tick_511k), 0);

    // Release and measure one full 5000-cycle window.
    #1 rst_n = 1'b1;
    first_rise = 0; rises = 0; ticks = 0; dbl_ticks = 0; last_rise = 0;
    per_min = 1000; per_max = 0; hi_run = 0; hi_min = 1000; hi_max = 0;
    rises2 = 0; prev_c = 1'b0; prev_t = 1'b0; prev_c2 = 1'b0;
    for (int cyc = 1; cyc <= T_MOD; cyc++) begin
      @(negedge clk);
      c = clk_511k;
      t = tick_511k;
      if (c && first_rise == 0) first_rise = cyc;
      if (cyc <= 10) begin
        check("mod10_level", int'(c2), cyc % 2);
        if (c2 && !prev_c2) rises2++;
        prev_c2 = c2;
      end
      if (cyc == 10) check("acc_after_10", int'(dut.u_acc.acc_q), 110);
      if (c && !prev_c) begin
        rises++;
        if (last_rise != 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
      end
      if (c) hi_run++;
      if (!c && prev_c) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
      end
      if (!c) hi_run = 0;
      if (t) ticks++;
      if (t && prev_t) dbl_ticks++;
      prev_c = c;
      prev_t = t;
    end
    check("first_rise_edge", first_rise, 5);
    check("mod10_rises", rises2, 5);
    check("rises_per_5000", rises, 511);
    check("ticks_per_5000", ticks, 511);
    check("acc_at_5000", int'(dut.u_acc.acc_q), 0);
    check("period_min", per_min, 9);
    check("period_max", per_max, 10);
    check("high_min", hi_min, 4);
    check("high_max", hi_max, 5);
    check("double_ticks", dbl_ticks, 0);

    // Random mid-run resets asserted while the output is high.
    for (int it = 0; it < 12; it++) begin
      int  n;
      bit  found;
      int  wait_cyc;
      n = $urandom_range(3, 200);
      repeat (n) @(negedge clk);
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
        @(negedge clk);
        if (clk_511k) found = 1'b1;
      end
      check("found_high_phase", int'(found), 1);
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      check("async_drop_clk", int'(clk_511k), 0);
      check("async_drop_tick", int'(tick_511k), 0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      #1 rst_n = 1'b1;
      wait_cyc = 0;
      for (int k = 1; k <= 20 && wait_cyc == 0; k++) begin
        @(negedge clk);
        if (clk_511k) wait_cyc = k;
      end
      check("restart_latency", wait_cyc, 5);
    end

    repeat (2) @(negedge clk);
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
